// File: rtl/waiter_route_fsm.sv
// Motion sequencer for the waiter robot: shuttles between base and table on a
// debounced call tone, with debounced arrival, pause/resume and a latching estop.
module waiter_route_fsm #(
    parameter int unsigned FREQ_W            = 10,
    parameter int unsigned THR_W             = 5,
    parameter int unsigned MIN_TRAVEL_CYCLES = 100_000_000,
    parameter int unsigned HOLD_CYCLES       = 1,
    parameter int unsigned ARRIVE_CYCLES     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FREQ_W-1:0] frequency_input,
    input  logic [THR_W-1:0]  threshold_frequency,
    input  logic              too_close,
    input  logic              hold,
    input  logic              estop,
    output logic [2:0]        direction,
    output logic              moving,
    output logic              arrived
);
    localparam int unsigned TMR_W = $clog2(MIN_TRAVEL_CYCLES + 1);
    localparam int unsigned HLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned ARR_W = $clog2(ARRIVE_CYCLES + 1);

    localparam logic [2:0] S_IDLE_BASE  = 3'b000;
    localparam logic [2:0] S_FORWARDS   = 3'b001;
    localparam logic [2:0] S_IDLE_TABLE = 3'b010;
    localparam logic [2:0] S_BACKWARDS  = 3'b011;
    localparam logic [2:0] S_STOP       = 3'b100;
    localparam logic [2:0] S_PAUSE_FWD  = 3'b101;
    localparam logic [2:0] S_PAUSE_BWD  = 3'b110;

    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(MIN_TRAVEL_CYCLES);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [ARR_W-1:0] ARR_LAST = ARR_W'(ARRIVE_CYCLES - 1);

    logic [2:0]       state, state_nx;
    logic [HLD_W-1:0] hold_cnt, hold_cnt_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic [ARR_W-1:0] arr_cnt, arr_cnt_nx;
    logic             armed, armed_nx;
    logic             moving_nx, arrived_nx;

    logic above, cond, trig, in_motion, in_idle, timer_done, arr;
    logic next_idle, next_motion, changing;

    assign above      = frequency_input > FREQ_W'(threshold_frequency);
    assign cond       = armed && above;
    assign trig       = cond && (hold_cnt == HLD_LAST);
    assign in_motion  = (state == S_FORWARDS) || (state == S_BACKWARDS);
    assign in_idle    = (state == S_IDLE_BASE) || (state == S_IDLE_TABLE);
    assign timer_done = (timer == TMR_MAX);
    assign arr        = in_motion && timer_done && too_close && (arr_cnt == ARR_LAST);

    assign direction  = state;

    // Next-state and counter update; estop outranks hold, which outranks arr/trig.
    always_comb begin
        state_nx = state;
        if (estop) begin
            state_nx = S_STOP;
        end else begin
            case (state)
                S_IDLE_BASE:  if (trig) state_nx = S_FORWARDS;
                S_IDLE_TABLE: if (trig) state_nx = S_BACKWARDS;
                S_FORWARDS: begin
                    if (hold)     state_nx = S_PAUSE_FWD;
                    else if (arr) state_nx = S_IDLE_TABLE;
                end
                S_BACKWARDS: begin
                    if (hold)     state_nx = S_PAUSE_BWD;
                    else if (arr) state_nx = S_IDLE_BASE;
                end
                S_PAUSE_FWD:  if (!hold) state_nx = S_FORWARDS;
                S_PAUSE_BWD:  if (!hold) state_nx = S_BACKWARDS;
                S_STOP:       if (trig) state_nx = S_IDLE_BASE;
                default:      state_nx = S_STOP;
            endcase
        end

        changing    = (state_nx != state);
        next_idle   = (state_nx == S_IDLE_BASE) || (state_nx == S_IDLE_TABLE);
        next_motion = (state_nx == S_FORWARDS) || (state_nx == S_BACKWARDS);

        hold_cnt_nx = '0;
        if (!changing && cond && (hold_cnt != HLD_LAST))
            hold_cnt_nx = hold_cnt + HLD_W'(1);
        else if (!changing && cond)
            hold_cnt_nx = hold_cnt;

        // Pause leaves the timer frozen; only a fresh departure clears it.
        timer_nx = timer;
        if (in_idle && next_motion)
            timer_nx = '0;
        else if (in_motion && !timer_done)
            timer_nx = timer + TMR_W'(1);

        arr_cnt_nx = '0;
        if (in_motion && timer_done && too_close)
            arr_cnt_nx = (arr_cnt == ARR_LAST) ? arr_cnt : arr_cnt + ARR_W'(1);

        // Entering an idle state disarms so a held tone cannot retrigger.
        armed_nx = armed;
        if (changing && next_idle)
            armed_nx = 1'b0;
        else if (!above)
            armed_nx = 1'b1;

        moving_nx  = next_motion;
        arrived_nx = in_motion && next_idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE_BASE;
            hold_cnt <= '0;
            timer    <= '0;
            arr_cnt  <= '0;
            armed    <= 1'b1;
            moving   <= 1'b0;
            arrived  <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            timer    <= timer_nx;
            arr_cnt  <= arr_cnt_nx;
            armed    <= armed_nx;
            moving   <= moving_nx;
            arrived  <= arrived_nx;
        end
    end
endmodule

// File: tb/tb_waiter_route_fsm.sv
// Bench for waiter_route_fsm: directed walk through the shuttle scenarios, then
// random traffic, all checked every cycle against a behavioural model.
module tb_waiter_route_fsm;
    localparam int MIN_T  = 8;
    localparam int HOLD_N = 3;
    localparam int ARR_N  = 2;

    localparam int IB = 0, FW = 1, IT = 2, BW = 3, ST = 4, PF = 5, PB = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] freq = '0;
    logic [4:0] thr = 5'd5;
    logic       too_close = 1'b0;
    logic       hold = 1'b0;
    logic       estop = 1'b0;
    logic [2:0] direction;
    logic       moving;
    logic       arrived;

    int checks = 0;
    int errors = 0;

    bit         pin_en = 1'b0;
    logic [2:0] pin_dir = '0;
    logic       pin_mov = 1'b0;
    logic       pin_arr = 1'b0;

    int m_st, m_tone, m_travel, m_close;
    bit m_armed, m_arrived;

    always #5 clk = ~clk;

    waiter_route_fsm #(
        .FREQ_W(10), .THR_W(5), .MIN_TRAVEL_CYCLES(MIN_T),
        .HOLD_CYCLES(HOLD_N), .ARRIVE_CYCLES(ARR_N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frequency_input(freq),
        .threshold_frequency(thr), .too_close(too_close), .hold(hold),
        .estop(estop), .direction(direction), .moving(moving), .arrived(arrived)
    );

    // Reference: run lengths and travel time as plain unbounded integers.
    initial begin : model
        bit tone, trg, mv, arv, entering;
        int nx;
        m_st = IB; m_armed = 1'b1; m_tone = 0; m_travel = 0; m_close = 0; m_arrived = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_st = IB; m_armed = 1'b1; m_tone = 0; m_travel = 0; m_close = 0; m_arrived = 1'b0;
            end else begin
                tone = m_armed && (int'(freq) > int'(thr));
                trg  = tone && (m_tone + 1 >= HOLD_N);
                mv   = (m_st == FW) || (m_st == BW);
                arv  = mv && (m_travel >= MIN_T) && too_close && (m_close + 1 >= ARR_N);
                nx = m_st;
                if (estop) nx = ST;
                else if (m_st == IB && trg) nx = FW;
                else if (m_st == IT && trg) nx = BW;
                else if (m_st == FW && hold) nx = PF;
                else if (m_st == FW && arv) nx = IT;
                else if (m_st == BW && hold) nx = PB;
                else if (m_st == BW && arv) nx = IB;
                else if (m_st == PF && !hold) nx = FW;
                else if (m_st == PB && !hold) nx = BW;
                else if (m_st == ST && trg) nx = IB;
                entering  = (nx != m_st);
                m_arrived = mv && (nx == IB || nx == IT);
                m_tone    = entering ? 0 : (tone ? m_tone + 1 : 0);
                m_close   = (mv && m_travel >= MIN_T && too_close) ? m_close + 1 : 0;
                if ((m_st == IB || m_st == IT) && (nx == FW || nx == BW)) m_travel = 0;
                else if (mv) m_travel = m_travel + 1;
                if (entering && (nx == IB || nx == IT)) m_armed = 1'b0;
                else if (int'(freq) <= int'(thr)) m_armed = 1'b1;
                m_st = nx;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("direction", 32'(direction), 32'(m_st));
            chk("moving", 32'(moving), 32'((m_st == FW) || (m_st == BW)));
            chk("arrived", 32'(arrived), 32'(m_arrived));
            if (pin_en) begin
                chk("pin_direction", 32'(direction), 32'(pin_dir));
                chk("pin_moving", 32'(moving), 32'(pin_mov));
                chk("pin_arrived", 32'(arrived), 32'(pin_arr));
            end
        end
    end

    task automatic step(input int f, input bit tc, input bit h, input bit e);
        freq = 10'(f); too_close = tc; hold = h; estop = e;
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic pin(input int d, input bit mv, input bit ar);
        pin_dir = 3'(d); pin_mov = mv; pin_arr = ar; pin_en = 1'b1;
    endtask

    initial begin : stim
        bit h_r, e_r;
        int f_r;
        step(0, 0, 0, 0); step(0, 0, 0, 0); pin(IB, 0, 0);
        rst_n = 1'b1;

        step(6, 0, 0, 0); step(6, 0, 0, 0); step(4, 0, 0, 0); pin(IB, 0, 0);
        step(6, 0, 0, 0); step(6, 0, 0, 0); pin(IB, 0, 0);
        step(6, 0, 0, 0); pin(FW, 1, 0);

        // too_close from the first moving cycle; arrival at MIN_T+ARR_N edges
        for (int i = 0; i < 9; i++) begin step(9, 1, 0, 0); pin(FW, 1, 0); end
        step(9, 1, 0, 0); pin(IT, 0, 1);
        step(9, 0, 0, 0); pin(IT, 0, 0);
        repeat (3) step(9, 0, 0, 0);
        pin(IT, 0, 0);
        step(3, 0, 0, 0); pin(IT, 0, 0);
        step(9, 0, 0, 0); step(9, 0, 0, 0); step(9, 0, 0, 0); pin(BW, 1, 0);

        repeat (4) step(3, 0, 0, 0);
        pin(BW, 1, 0);
        step(3, 0, 1, 0); pin(PB, 0, 0);
        repeat (9) step(3, 0, 1, 0);
        pin(PB, 0, 0);
        step(3, 1, 0, 0); pin(BW, 1, 0);
        for (int i = 0; i < 4; i++) begin step(3, 1, 0, 0); pin(BW, 1, 0); end
        step(3, 1, 0, 0); pin(IB, 0, 1);

        step(3, 0, 0, 0); step(9, 0, 0, 0); step(9, 0, 0, 0); step(9, 0, 0, 0); pin(FW, 1, 0);
        for (int i = 0; i < 9; i++) begin step(3, 1, 0, 0); pin(FW, 1, 0); end
        step(3, 1, 0, 1); pin(ST, 0, 0);
        step(9, 0, 0, 0); step(9, 0, 0, 0); pin(ST, 0, 0);
        step(9, 0, 0, 0); pin(IB, 0, 0);

        step(3, 0, 0, 0); step(9, 0, 0, 0); step(9, 0, 0, 0); step(9, 0, 0, 0); pin(FW, 1, 0);
        step(3, 0, 1, 0); pin(PF, 0, 0);
        step(3, 0, 1, 0); pin(PF, 0, 0);
        rst_n = 1'b0; pin(IB, 0, 0);
        step(3, 0, 1, 0); pin(IB, 0, 0);
        rst_n = 1'b1;

        h_r = 1'b0; e_r = 1'b0; f_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) f_r = int'($urandom_range(0, 40));
            if ($urandom_range(0, 19) == 0) h_r = ~h_r;
            e_r = ($urandom_range(0, 149) == 0) || (e_r && $urandom_range(0, 2) != 0);
            if (i % 500 == 499) thr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
            step(f_r, 1'($urandom_range(0, 1)), h_r, e_r);
            rst_n = 1'b1;
        end

        step(0, 0, 0, 0); step(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/waiter_route_fsm.md
# waiter_route_fsm

Parametrised motion-sequencing FSM for the waiter robot. It decides when the robot drives between base and table, using three inputs: the FFT frequency estimate (the call tone), the ultrasonic `too_close` flag, and operator `hold`/`estop` inputs. It sits between the FFT/ultrasonic front-ends and the motor driver, which decodes `direction`. It adds several things to the basic base/table shuttle:
- debounced tone triggering with a re-arm rule
- debounced arrival detection
- pause/resume with the travel timer frozen
- a latching emergency stop

## Interface
Parameters:
- `FREQ_W`, 10, width of `frequency_input`
- `THR_W`, 5, width of `threshold_frequency`
- `MIN_TRAVEL_CYCLES`, 100_000_000, minimum moving cycles before arrival is accepted (2 s at 50 MHz); ≥1
- `HOLD_CYCLES`, 1, consecutive above-threshold cycles needed to trigger; ≥1
- `ARRIVE_CYCLES`, 1, consecutive `too_close` cycles needed for arrival; ≥1

Ports:
- `clk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  reset, asynchronous, active-low
- `frequency_input`  in  FREQ_W  current dominant frequency bin
- `threshold_frequency`  in  THR_W  trigger threshold, zero-extended to FREQ_W for comparison
- `too_close`  in  1  ultrasonic proximity flag, synchronous to `clk`
- `hold`  in  1  pause request, level, synchronous
- `estop`  in  1  emergency stop, level, synchronous
- `direction`  out  3  current state encoding (below)
- `moving`  out  1  high in FORWARDS or BACKWARDS
- `arrived`  out  1  one-cycle pulse on entry to IDLE_TABLE or IDLE_BASE from travel

## Operation
- States and encodings:
  - IDLE_BASE=000, FORWARDS=001, IDLE_TABLE=010, BACKWARDS=011
  - STOP=100, PAUSE_FWD=101, PAUSE_BWD=110
  - 111 is unreachable and recovers to STOP next cycle.
- Trigger condition: `armed` && `frequency_input` > {0,`threshold_frequency`}.
  - `hold_cnt` increments while the condition is true and clears when it is false.
  - `trig` fires when the condition is true with `hold_cnt` == HOLD_CYCLES-1.
  - `hold_cnt` clears on every state change.
- Re-arm rule:
  - `armed` = 1 at reset.
  - `armed` is cleared on every entry to IDLE_BASE or IDLE_TABLE.
  - `armed` is set by any cycle with `frequency_input` ≤ threshold.
  - Consequence: a tone held through arrival never immediately retriggers.
- Travel timer:
  - Cleared on entry to FORWARDS/BACKWARDS from an idle state.
  - Increments in FORWARDS/BACKWARDS, saturating at MIN_TRAVEL_CYCLES.
  - Frozen in PAUSE_*; not cleared by pause/resume.
- Arrival counter:
  - Counts consecutive `too_close` cycles in FORWARDS/BACKWARDS while the timer ≥ MIN_TRAVEL_CYCLES.
  - Clears otherwise.
  - `arr` fires when `too_close` is high with the counter == ARRIVE_CYCLES-1.
  - `too_close` is ignored before the timer saturates.
- Transitions, in priority order estop > hold > arr/trig:
  - Any state with `estop`=1 → STOP.
  - IDLE_BASE: `trig` → FORWARDS.
  - IDLE_TABLE: `trig` → BACKWARDS.
  - FORWARDS: `hold` → PAUSE_FWD; `arr` → IDLE_TABLE.
  - BACKWARDS: `hold` → PAUSE_BWD; `arr` → IDLE_BASE.
  - PAUSE_FWD/PAUSE_BWD: `hold`=0 → FORWARDS/BACKWARDS. The timer resumes and the arrival counter restarts from 0.
  - STOP: `estop`=0 and `trig` → IDLE_BASE. STOP is latching; the operator returns the robot to base manually.
- Counter widths are $clog2(max+1) of their parameter; no counter wraps.

## Timing
- Reset (asynchronous): state IDLE_BASE, `direction`=000, `moving`=0, `arrived`=0, all counters 0, `armed`=1.
  - Release is synchronous to the next `clk` edge.
- State is registered. Inputs sampled at edge N take effect on `direction`/`moving` after edge N; one cycle of latency.
- `arrived` is registered and is high for exactly the first cycle of the new idle state.
- Trigger: from an idle state with `armed`=1, a tone high for HOLD_CYCLES consecutive edges changes state at the HOLD_CYCLES-th edge.
- Minimum arrival: after entering FORWARDS, the earliest `arrived` pulse is MIN_TRAVEL_CYCLES+ARRIVE_CYCLES edges later, excluding paused cycles.
- Simultaneous `estop` and `hold`/`arr`/`trig`: STOP wins, and no `arrived` pulse is generated.
- `hold` and `arr` in the same cycle: pause wins; arrival is re-evaluated after resume.
- Reset asserted mid-travel: immediate IDLE_BASE; the timer is lost.

## Test plan
(Parameters: MIN_TRAVEL_CYCLES=8, HOLD_CYCLES=3, ARRIVE_CYCLES=2, threshold 5.)
- Reset, then freq=6 for 2 cycles then 4 → stays IDLE_BASE. Freq=6 for 3 cycles → `direction`=001 after the 3rd edge, `moving`=1.
- In FORWARDS, `too_close`=1 from cycle 0 → no arrival before timer=8. Arrival 2 edges after saturation: `direction`=010, `arrived` pulse 1 cycle.
- Keep freq=9 through arrival → stays IDLE_TABLE. Drop to 3 for 1 cycle, then 9 for 3 cycles → BACKWARDS (011).
- In BACKWARDS at timer=4, `hold`=1 for 10 cycles → 110, `moving`=0. Release → 011. Arrival needs 4 more moving cycles plus 2 `too_close` cycles.
- `estop` pulsed while FORWARDS with `arr` due the same cycle → 100, no `arrived`. `estop`=0 with freq=9 for 3 cycles (armed) → 000.
- `rst_n` low asynchronously mid-PAUSE_FWD → `direction`=000 before the next edge. All outputs are at reset values.
